// File: rtl/aes_block_sequencer.sv
// aes_block_sequencer
// Control sequencer for a block-oriented AES datapath. It runs an
// optional key expansion, then for each 128-bit block it collects four
// 32-bit input words, starts the AES core, waits for it to finish,
// loads the result into the TX shift register, and drains four output
// words. After the last block it pulses done.
//
// Ports
//   clk, rst            clock; synchronous active-high reset
//   start               begin an operation (sampled only in IDLE)
//   encrypt             mode, latched at an accepted start
//   change_key          run key expansion before the first block
//   num_blocks          block count, latched at an accepted start
//   abort               cancel the current operation (ignored in IDLE)
//   key_done, aes_done  completion pulses from key generator / AES core
//   in_valid/in_ready   32-bit input stream handshake
//   out_valid/out_ready 32-bit output stream handshake
//   key_start, aes_start, tx_load   one-cycle control pulses
//   rx_shift_en, tx_shift_en        shift-register enables
//   mode_enc            latched encrypt value
//   busy, done          status
module aes_block_sequencer #(
  parameter int CNT_W = 28
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             encrypt,
  input  logic             change_key,
  input  logic [CNT_W-1:0] num_blocks,
  input  logic             abort,
  input  logic             key_done,
  input  logic             aes_done,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             key_start,
  output logic             aes_start,
  output logic             mode_enc,
  output logic             rx_shift_en,
  output logic             tx_load,
  output logic             tx_shift_en,
  output logic             busy,
  output logic             done
);

  typedef enum logic [3:0] {
    S_IDLE,
    S_KEY_START,
    S_KEY_WAIT,
    S_FILL,
    S_AES_START,
    S_AES_WAIT,
    S_TX_LOAD,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] blocks_left;
  logic [1:0]       word_cnt;
  logic             key_req;   // key expansion still owed for this operation
  logic             kill;      // abort honoured this cycle

  assign kill = abort & (state != S_IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      blocks_left <= '0;
      word_cnt    <= 2'd0;
      key_req     <= 1'b0;
      mode_enc    <= 1'b0;
    end else begin
      state <= state_nxt;
      if (kill) begin
        blocks_left <= '0;
        word_cnt    <= 2'd0;
        key_req     <= 1'b0;
      end else begin
        case (state)
          S_IDLE: begin
            if (start && num_blocks != '0) begin
              mode_enc    <= encrypt;
              key_req     <= change_key;
              blocks_left <= num_blocks;
              word_cnt    <= 2'd0;
            end
          end
          // Key expansion happens once per operation, never per block.
          S_KEY_START: key_req <= 1'b0;
          S_FILL: begin
            if (rx_shift_en) word_cnt <= word_cnt + 2'd1;
          end
          S_DRAIN: begin
            if (tx_shift_en) begin
              word_cnt <= word_cnt + 2'd1;
              if (word_cnt == 2'd3 && blocks_left != '0)
                blocks_left <= blocks_left - CNT_W'(1);
            end
          end
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    state_nxt   = state;
    busy        = (state != S_IDLE);
    in_ready    = (state == S_FILL);
    out_valid   = (state == S_DRAIN);
    rx_shift_en = in_valid & in_ready;
    tx_shift_en = out_valid & out_ready;
    // Pulses are suppressed in the cycle an abort is taken.
    key_start   = (state == S_KEY_START) & key_req & ~kill;
    aes_start   = (state == S_AES_START) & ~kill;
    tx_load     = (state == S_TX_LOAD) & ~kill;
    done        = (state == S_DONE) & ~kill;

    case (state)
      S_IDLE: begin
        if (start) begin
          if (num_blocks == '0)  state_nxt = S_DONE;
          else if (change_key)   state_nxt = S_KEY_START;
          else                   state_nxt = S_FILL;
        end
      end
      S_KEY_START: state_nxt = S_KEY_WAIT;
      // Waits only react to pulses seen while already in the wait state.
      S_KEY_WAIT:  if (key_done) state_nxt = S_FILL;
      S_FILL:      if (rx_shift_en && word_cnt == 2'd3) state_nxt = S_AES_START;
      S_AES_START: state_nxt = S_AES_WAIT;
      S_AES_WAIT:  if (aes_done) state_nxt = S_TX_LOAD;
      S_TX_LOAD:   state_nxt = S_DRAIN;
      S_DRAIN: begin
        if (tx_shift_en && word_cnt == 2'd3)
          state_nxt = (blocks_left == CNT_W'(1)) ? S_DONE : S_FILL;
      end
      S_DONE:      state_nxt = S_IDLE;
      default:     state_nxt = S_IDLE;
    endcase

    if (kill) state_nxt = S_IDLE;
  end

endmodule

// File: doc/aes_block_sequencer.md
AES_BLOCK_SEQUENCER -- requirements
Module: aes_block_sequencer

Interface
REQ-001 Parameter CNT_W, default 28, is the width of the block-count input and internal counter.
REQ-002 clk  input  1  system clock; all state changes on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 start  input  1  one-cycle request to begin an operation; sampled only in IDLE.
REQ-005 encrypt  input  1  mode (1=encrypt, 0=decrypt); latched at accepted start.
REQ-006 change_key  input  1  key expansion required before the first block; latched at accepted start.
REQ-007 num_blocks  input  CNT_W  number of 128-bit blocks; latched at accepted start.
REQ-008 abort  input  1  synchronous cancel of the current operation.
REQ-009 key_done  input  1  key-expansion-complete pulse from the key generator.
REQ-010 aes_done  input  1  block-complete pulse from the AES core.
REQ-011 in_valid  input  1  input word available on the 32-bit input stream.
REQ-012 in_ready  output  1  sequencer accepts an input word.
REQ-013 out_valid  output  1  output word presented by the TX shift register.
REQ-014 out_ready  input  1  downstream accepts an output word.
REQ-015 key_start  output  1  one-cycle pulse starting key expansion.
REQ-016 aes_start  output  1  one-cycle pulse starting one AES block.
REQ-017 mode_enc  output  1  latched encrypt value, held for the whole operation.
REQ-018 rx_shift_en  output  1  shift one word into the RX shift register.
REQ-019 tx_load  output  1  one-cycle pulse loading the AES result into the TX shift register.
REQ-020 tx_shift_en  output  1  shift one word out of the TX shift register.
REQ-021 busy  output  1  high in every state except IDLE.
REQ-022 done  output  1  one-cycle pulse on normal completion.

Function
REQ-023 States: IDLE, KEY_START, KEY_WAIT, FILL, AES_START, AES_WAIT, TX_LOAD, DRAIN, DONE.
REQ-024 IDLE with start=1 and num_blocks!=0 latches encrypt, change_key, and num_blocks into blocks_left, then moves to KEY_START if change_key=1, else to FILL.
REQ-025 IDLE with start=1 and num_blocks=0 moves to DONE; no key, AES, or stream activity occurs.
REQ-026 KEY_START asserts key_start for exactly 1 cycle and moves to KEY_WAIT.
REQ-027 KEY_WAIT holds until key_done=1, then moves to FILL.
REQ-028 FILL asserts in_ready=1; rx_shift_en = in_valid & in_ready, combinational, in the same cycle.
REQ-029 FILL increments a 2-bit word counter per accepted word; the 4th accepted word moves to AES_START and the counter wraps to 0.
REQ-030 AES_START asserts aes_start for 1 cycle and moves to AES_WAIT.
REQ-031 AES_WAIT holds until aes_done=1, then moves to TX_LOAD.
REQ-032 TX_LOAD asserts tx_load for 1 cycle and moves to DRAIN.
REQ-033 DRAIN asserts out_valid=1; tx_shift_en = out_valid & out_ready.
REQ-034 DRAIN counts 4 accepted words; on the 4th, if blocks_left=1 it moves to DONE, else it decrements blocks_left and moves to FILL.
REQ-035 Key expansion is never repeated between blocks of one operation.
REQ-036 DONE asserts done for 1 cycle and moves to IDLE.
REQ-037 Minimum latency for one block without key change, with zero stall: start, 4 FILL, 1 AES_START, AES_WAIT(n), 1 TX_LOAD, 4 DRAIN, then done 1 cycle later.
REQ-038 start while busy=1 is ignored.
REQ-039 key_done outside KEY_WAIT is ignored.
REQ-040 aes_done outside AES_WAIT is ignored.
REQ-041 key_done or aes_done arriving in the same cycle as entry to the waiting state is not counted; the pulse must arrive while already in that state.
REQ-042 abort=1 in any non-IDLE state forces IDLE on the next edge: done stays 0, counters clear, and pulse outputs are 0 that cycle.
REQ-043 abort has priority over all other transitions; abort in IDLE has no effect.
REQ-044 in_ready, out_valid, rx_shift_en, and tx_shift_en are 0 outside FILL or DRAIN respectively.
REQ-045 in_valid without in_ready, and out_ready without out_valid, have no effect.
REQ-046 blocks_left counts down only at block completion and never underflows.

Reset
REQ-047 rst=1 at a clock edge forces IDLE and clears blocks_left, the word counter, and the latched mode and flags, regardless of state.
REQ-048 Output values during and after reset: busy=0, done=0, key_start=0, aes_start=0, tx_load=0, in_ready=0, out_valid=0, rx_shift_en=0, tx_shift_en=0, mode_enc=0.
REQ-049 rst has priority over abort and start.

Verification
REQ-050 Single block: start, encrypt=1, change_key=1, num_blocks=1, key_done 5 cycles later, aes_done 11 cycles after aes_start -> exactly 1 key_start, 4 rx_shift_en, 1 aes_start, 1 tx_load, 4 tx_shift_en, then 1 done; mode_enc=1 throughout.
REQ-051 Three blocks, change_key=0 -> no key_start, 3 aes_start, 12 rx_shift_en, 12 tx_shift_en, 1 done after the last DRAIN word.
REQ-052 Stalls: in_valid toggling 1/0 and out_ready low for 3 cycles mid-DRAIN -> word counts still exactly 4 per phase, no shifts while stalled.
REQ-053 num_blocks=0 -> done 1 cycle after start, busy high 1 cycle, no other outputs.
REQ-054 abort in AES_WAIT of block 2 of 4 -> IDLE next cycle, no done; a fresh start with change_key=1 then runs normally.
REQ-055 Spurious pulses: aes_done in FILL, key_done in IDLE, and start while busy -> no state change; rst mid-DRAIN -> all outputs 0 next cycle.
